apb_dbg_bridge: RTL and testbench
=================================

# apb_dbg_bridge

Byte-stream-to-APB initiator allowing an external host to read and write the system address map without the core. Command bytes arrive on a valid/ready byte channel, normally fed by a UART receiver. The bridge issues one APB transfer per command and returns status and read data on a second byte channel. In the top level it is a second initiator port in front of `apb_fabric`, alongside `core_top`.

## Interface
- `ADDR_W`, 34: `paddr` width; matches the core initiator port. Command address bits above 31 are driven 0.
- `TIMEOUT_CYCLES`, 1024: maximum ACCESS cycles before abort. Used only with `APB_DBG_TIMEOUT_EN`.
- `clk`  input  1  clock.
- `rst`  input  1  reset; synchronous, active-high.
- `rx_data`  input  8  command byte.
- `rx_valid`  input  1  `rx_data` valid.
- `rx_ready`  output  1  bridge accepts command byte.
- `tx_data`  output  8  response byte.
- `tx_valid`  output  1  `tx_data` valid.
- `tx_ready`  input  1  sink accepts response byte.
- `psel`, `penable`, `pwrite`  output  1  APB control.
- `paddr`  output  ADDR_W  APB address.
- `pwdata`  output  32  write data.
- `pwstrb`  output  4  write strobes.
- `pready`, `pslverr`  input  1  APB completion and error.
- `prdata`  input  32  read data.

## Operation
- Command formats (all multi-byte fields little-endian):
  - Read: `0x01`, then 4 address bytes.
  - Write: `0x02`, then 4 address bytes, then 4 data bytes.
  - Masked write: `0x03`, then 4 address bytes, then 4 data bytes, then 1 strobe byte (bits 3:0 used).
- Response formats:
  - Status byte: `0x00` OK, `0x01` PSLVERR, `0x02` timeout, `0xFF` bad opcode.
  - A read with status OK or PSLVERR is followed by 4 `prdata` bytes, LSB first.
- States: IDLE, ADDR, DATA, STRB, SETUP, ACCESS, RESP.
- Byte transfer occurs when `rx_valid && rx_ready` at a rising edge.
- `rx_ready` is 1 in IDLE/ADDR/DATA/STRB and 0 elsewhere. It is combinational from state.
- Transitions:
  - IDLE:
    - Valid opcode → ADDR.
    - Any other opcode → RESP with a 1-byte `0xFF` response.
  - ADDR: after 4 bytes → SETUP on a read, otherwise → DATA.
  - DATA: after 4 bytes → SETUP on opcode `0x02`, → STRB on `0x03`.
  - STRB: 1 byte → SETUP.
  - SETUP: 1 cycle, `psel=1`, `penable=0` → ACCESS.
  - ACCESS: `psel=1`, `penable=1` until `pready`. On `pready`:
    - capture `prdata` and `pslverr`;
    - deassert `psel`/`penable` next cycle;
    - → RESP.
  - RESP: present bytes in order; each advances on `tx_valid && tx_ready`. After the last byte → IDLE.
- `pwstrb`: `4'hF` for opcode `0x02`, the strobe byte[3:0] for `0x03`, `4'h0` for reads.
- `paddr`, `pwrite`, `pwdata`, `pwstrb` are stable from SETUP through the end of ACCESS.
- Byte-index counter: 2 bits for fields, 3 bits for the response.

## Timing
- Reset values:
  - `psel`, `penable`, `pwrite` = 0.
  - `paddr`, `pwdata`, `pwstrb`, `tx_data` = 0.
  - `tx_valid` = 0.
  - State = IDLE.
- `rst` during any state:
  - Discards the partial command or response.
  - Drops `psel` at that edge.
- Latency:
  - Last command byte accepted at edge N → SETUP in cycle N+1, ACCESS in N+2.
  - `pready` sampled high at edge M → `tx_valid=1` in cycle M+1.
- `tx_valid` stays high and `tx_data` stays constant until `tx_ready`; no bubble between response bytes when `tx_ready` is held high.
- No command bytes are accepted while in SETUP/ACCESS/RESP. Back-pressure is held on `rx_ready`.
- Zero-wait-state target: ACCESS lasts exactly 1 cycle.

## Configuration
- `APB_DBG_TIMEOUT_EN` defined:
  - ACCESS cycles are counted.
  - If `TIMEOUT_CYCLES` cycles elapse without `pready`: drop `psel`/`penable`, respond `0x02` with no data bytes, return to IDLE.
  - A `pready` arriving in the same cycle the count expires takes precedence over the timeout.
- `APB_DBG_TIMEOUT_EN` undefined: the bridge waits indefinitely and status `0x02` is never generated.

## Structure
- Package `apb_dbg_pkg` holds:
  - opcode constants (`0x01`/`0x02`/`0x03`);
  - status constants (`0x00`/`0x01`/`0x02`/`0xFF`);
  - the state enum typedef.
- Single module. No sub-module is warranted: the field shift registers, byte counter and timeout counter are each a few lines.

## Test plan
- Read of `0x0000_1000` with 0-wait target returning `0xDEADBEEF`:
  - stimulus bytes `01 00 10 00 00`;
  - response `00 EF BE AD DE`;
  - exactly one SETUP and one ACCESS cycle.
- Write of `0x1234_5678` to `0x0000_0020` with 2 wait states:
  - stimulus `02 20 00 00 00 78 56 34 12`;
  - `pwdata=0x12345678`, `pwstrb=F`;
  - 3 ACCESS cycles;
  - response `00`.
- Masked write with strobe byte `05`: `pwstrb=4'b0101`; response `00`.
- Read with `pslverr=1`: response `01` plus 4 data bytes. Then opcode `0x7E`: response `FF`, no APB activity.
- `tx_ready` low for 5 cycles mid-response: `tx_valid` and `tx_data` hold, and no byte is lost or duplicated.
- With `APB_DBG_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`, `pready` tied 0:
  - `psel` drops after 8 ACCESS cycles;
  - response `02`.
  - Separately, `rst` asserted during ACCESS: `psel=0` next cycle and no response is emitted.

Source files
------------

// File: rtl/apb_dbg_pkg.sv
// apb_dbg_pkg
//   Shared constants and types for apb_dbg_bridge.
//   - Command opcodes: the first byte of every host command.
//   - Status codes: the first byte of every response.
//   - Bridge FSM state encoding.
package apb_dbg_pkg;

    localparam logic [7:0] OP_READ   = 8'h01;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_MWRITE = 8'h03;

    localparam logic [7:0] STS_OK      = 8'h00;
    localparam logic [7:0] STS_SLVERR  = 8'h01;
    localparam logic [7:0] STS_TIMEOUT = 8'h02;
    localparam logic [7:0] STS_BAD_OP  = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_STRB,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/apb_dbg_bridge.sv
// apb_dbg_bridge
//   Byte-stream to APB initiator. The host sends commands over a valid/ready
//   byte channel. The bridge runs one APB transfer per command and returns a
//   status byte, plus 4 read-data bytes for reads, over a second byte channel.
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     rx_data/rx_valid/rx_ready  command byte channel (bridge is the sink)
//     tx_data/tx_valid/tx_ready  response byte channel (bridge is the source)
//     psel/penable/pwrite/paddr/pwdata/pwstrb  APB initiator outputs
//     pready/pslverr/prdata                    APB completer inputs
//
//   Build option
//     APB_DBG_TIMEOUT_EN  when defined, an ACCESS phase that gets no pready
//                         within TIMEOUT_CYCLES cycles is abandoned and answered
//                         with status 0x02. When undefined, the bridge waits
//                         for pready indefinitely.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for an opcode byte
//   ADDR   | collecting 4 address bytes, LSB first
//   DATA   | collecting 4 write-data bytes, LSB first
//   STRB   | collecting the strobe byte of a masked write
//   SETUP  | APB setup phase (psel=1, penable=0)
//   ACCESS | APB access phase, waiting for pready
//   RESP   | streaming the status byte and any read-data bytes
module apb_dbg_bridge
    import apb_dbg_pkg::*;
#(
    parameter int ADDR_W         = 34,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    output logic [3:0]        pwstrb,
    input  logic              pready,
    input  logic              pslverr,
    input  logic [31:0]       prdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
        $error("apb_dbg_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    state_e      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic        write_q, write_d;
    logic [1:0]  fld_idx_q, fld_idx_d;
    logic [2:0]  rsp_idx_q, rsp_idx_d;
    logic        rsp_has_data_q, rsp_has_data_d;
    logic [7:0]  status_q, status_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  rsp_last;

`ifdef APB_DBG_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign rx_ready = (state_q == ST_IDLE) || (state_q == ST_ADDR) ||
                      (state_q == ST_DATA) || (state_q == ST_STRB);
    assign psel     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign penable  = (state_q == ST_ACCESS);
    assign pwrite   = write_q;
    assign paddr    = ADDR_W'(addr_q);
    assign pwdata   = wdata_q;
    assign pwstrb   = strb_q;
    assign tx_valid = (state_q == ST_RESP);
    assign rsp_last = rsp_has_data_q ? 3'd4 : 3'd0;

    always_comb begin
        tx_data = 8'h00;
        if (state_q == ST_RESP) begin
            case (rsp_idx_q)
                3'd0:    tx_data = status_q;
                3'd1:    tx_data = rdata_q[7:0];
                3'd2:    tx_data = rdata_q[15:8];
                3'd3:    tx_data = rdata_q[23:16];
                3'd4:    tx_data = rdata_q[31:24];
                default: tx_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        strb_d         = strb_q;
        write_d        = write_q;
        fld_idx_d      = fld_idx_q;
        rsp_idx_d      = rsp_idx_q;
        rsp_has_data_d = rsp_has_data_q;
        status_d       = status_q;
        rdata_d        = rdata_q;
`ifdef APB_DBG_TIMEOUT_EN
        tmo_d          = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    fld_idx_d = 2'd0;
                    case (rx_data)
                        OP_READ: begin
                            opcode_d = rx_data;
                            write_d  = 1'b0;
                            strb_d   = 4'h0;
                            state_d  = ST_ADDR;
                        end
                        OP_WRITE: begin
                            opcode_d = rx_data;
                            write_d  = 1'b1;
                            strb_d   = 4'hF;
                            state_d  = ST_ADDR;
                        end
                        OP_MWRITE: begin
                            opcode_d = rx_data;
                            write_d  = 1'b1;
                            strb_d   = 4'h0;
                            state_d  = ST_ADDR;
                        end
                        default: begin
                            status_d       = STS_BAD_OP;
                            rsp_has_data_d = 1'b0;
                            rsp_idx_d      = 3'd0;
                            state_d        = ST_RESP;
                        end
                    endcase
                end
            end

            // Fields arrive LSB first, so each byte is shifted in from the top.
            ST_ADDR: begin
                if (rx_valid) begin
                    addr_d    = {rx_data, addr_q[31:8]};
                    fld_idx_d = fld_idx_q + 2'd1;
                    if (fld_idx_q == 2'd3) begin
                        state_d = (opcode_q == OP_READ) ? ST_SETUP : ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (rx_valid) begin
                    wdata_d   = {rx_data, wdata_q[31:8]};
                    fld_idx_d = fld_idx_q + 2'd1;
                    if (fld_idx_q == 2'd3) begin
                        state_d = (opcode_q == OP_WRITE) ? ST_SETUP : ST_STRB;
                    end
                end
            end

            ST_STRB: begin
                if (rx_valid) begin
                    strb_d  = rx_data[3:0];
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
`ifdef APB_DBG_TIMEOUT_EN
                tmo_d   = TMO_LOAD;
`endif
                state_d = ST_ACCESS;
            end

            // pready is checked first so a completion in the last allowed
            // cycle wins over the timeout.
            ST_ACCESS: begin
                if (pready) begin
                    rdata_d        = prdata;
                    status_d       = pslverr ? STS_SLVERR : STS_OK;
                    rsp_has_data_d = (opcode_q == OP_READ);
                    rsp_idx_d      = 3'd0;
                    state_d        = ST_RESP;
                end
`ifdef APB_DBG_TIMEOUT_EN
                else if (tmo_q == '0) begin
                    status_d       = STS_TIMEOUT;
                    rsp_has_data_d = 1'b0;
                    rsp_idx_d      = 3'd0;
                    state_d        = ST_RESP;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
`endif
            end

            ST_RESP: begin
                if (tx_ready) begin
                    if (rsp_idx_q == rsp_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        rsp_idx_d = rsp_idx_q + 3'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            opcode_q       <= 8'h00;
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            strb_q         <= 4'h0;
            write_q        <= 1'b0;
            fld_idx_q      <= 2'd0;
            rsp_idx_q      <= 3'd0;
            rsp_has_data_q <= 1'b0;
            status_q       <= STS_OK;
            rdata_q        <= 32'h0;
`ifdef APB_DBG_TIMEOUT_EN
            tmo_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            strb_q         <= strb_d;
            write_q        <= write_d;
            fld_idx_q      <= fld_idx_d;
            rsp_idx_q      <= rsp_idx_d;
            rsp_has_data_q <= rsp_has_data_d;
            status_q       <= status_d;
            rdata_q        <= rdata_d;
`ifdef APB_DBG_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_dbg_bridge.sv
module tb_apb_dbg_bridge;

`ifdef APB_DBG_TIMEOUT_EN
    localparam int TB_TMO = 8;
`else
    localparam int TB_TMO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        psel, penable, pwrite;
    logic [33:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pwstrb;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int wait_states = 0;
    bit hang        = 1'b0;
    int acc_run     = 0;

    int setup_n, access_n, setup_at, pr_edge, tx_at, txv_n, stable_bad, last_acc;
    logic [33:0] snap_addr;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_strb;
    logic        snap_write;
    logic [7:0]  rsp_q[$];

    apb_dbg_bridge #(.ADDR_W(34), .TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pwstrb(pwstrb),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // APB completer, bus monitor and response collector, all on the falling edge.
    always @(negedge clk) begin
        if (psel && penable) begin
            pready = !hang && (acc_run == wait_states);
            acc_run++;
        end else begin
            pready  = 1'b0;
            acc_run = 0;
        end
        if (psel && !penable) begin
            setup_n++;
            if (setup_at < 0) setup_at = cyc;
            snap_addr  = paddr;
            snap_wdata = pwdata;
            snap_strb  = pwstrb;
            snap_write = pwrite;
        end
        if (psel && penable) begin
            access_n++;
            if (paddr !== snap_addr || pwdata !== snap_wdata ||
                pwstrb !== snap_strb || pwrite !== snap_write) stable_bad++;
            if (pready && pr_edge < 0) pr_edge = cyc + 1;
        end
        if (tx_valid) begin
            txv_n++;
            if (tx_at < 0) tx_at = cyc;
            if (tx_ready) rsp_q.push_back(tx_data);
        end
    end

    task automatic clear_mon();
        setup_n = 0; access_n = 0; setup_at = -1; pr_edge = -1;
        tx_at = -1; txv_n = 0; stable_bad = 0; last_acc = -1;
        rsp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            total++; bad++;
            $display("FAIL send_byte: rx_ready=%b after %0d cycles, required 1", rx_ready, n);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            last_acc = cyc;
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_cmd(input logic [7:0] b [10], input int n);
        for (int i = 0; i < n; i++) send_byte(b[i]);
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (psel !== 1'b0)     begin bad++; $display("FAIL rst_psel: got %b want 0", psel); end
        total++; if (penable !== 1'b0)  begin bad++; $display("FAIL rst_penable: got %b want 0", penable); end
        total++; if (pwrite !== 1'b0)   begin bad++; $display("FAIL rst_pwrite: got %b want 0", pwrite); end
        total++; if (paddr !== 34'h0)   begin bad++; $display("FAIL rst_paddr: got %h want 0", paddr); end
        total++; if (pwdata !== 32'h0)  begin bad++; $display("FAIL rst_pwdata: got %h want 0", pwdata); end
        total++; if (pwstrb !== 4'h0)   begin bad++; $display("FAIL rst_pwstrb: got %h want 0", pwstrb); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rst_rx_ready: got %b want 1", rx_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        logic [7:0] cmd [10];
        logic [7:0] exp [5];
        logic [7:0] got;
        clear_mon();
        prdata = 32'hDEADBEEF; pslverr = 1'b0; wait_states = 0;
        cmd = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 5);
        wait_rsp(5);
        exp = '{8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        total++; if (rsp_q.size() !== 5) begin bad++; $display("FAIL read_rsp_len: got %0d want 5", rsp_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < rsp_q.size()) ? rsp_q[i] : 8'hxx;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL read_rsp_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        total++; if (setup_n !== 1)    begin bad++; $display("FAIL read_setup_cycles: got %0d want 1", setup_n); end
        total++; if (access_n !== 1)   begin bad++; $display("FAIL read_access_cycles: got %0d want 1", access_n); end
        total++; if (snap_addr !== 34'h0_0000_1000) begin bad++; $display("FAIL read_paddr: got %h want 1000", snap_addr); end
        total++; if (snap_write !== 1'b0) begin bad++; $display("FAIL read_pwrite: got %b want 0", snap_write); end
        total++; if (snap_strb !== 4'h0)  begin bad++; $display("FAIL read_pwstrb: got %h want 0", snap_strb); end
        total++; if (setup_at !== last_acc) begin bad++; $display("FAIL read_setup_latency: got cycle %0d want %0d", setup_at, last_acc); end
        total++; if (tx_at !== pr_edge)   begin bad++; $display("FAIL read_tx_latency: got cycle %0d want %0d", tx_at, pr_edge); end
        total++; if (txv_n !== 5)         begin bad++; $display("FAIL read_tx_no_bubble: got %0d valid cycles want 5", txv_n); end
    endtask

    task automatic test_write();
        logic [7:0] cmd [10];
        logic [7:0] got;
        clear_mon();
        pslverr = 1'b0; wait_states = 2;
        cmd = '{8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
        send_cmd(cmd, 9);
        wait_rsp(1);
        got = (rsp_q.size() > 0) ? rsp_q[0] : 8'hxx;
        total++; if (rsp_q.size() !== 1) begin bad++; $display("FAIL write_rsp_len: got %0d want 1", rsp_q.size()); end
        total++; if (got !== 8'h00)      begin bad++; $display("FAIL write_status: got %h want 00", got); end
        total++; if (snap_wdata !== 32'h12345678) begin bad++; $display("FAIL write_pwdata: got %h want 12345678", snap_wdata); end
        total++; if (snap_strb !== 4'hF)  begin bad++; $display("FAIL write_pwstrb: got %h want f", snap_strb); end
        total++; if (snap_write !== 1'b1) begin bad++; $display("FAIL write_pwrite: got %b want 1", snap_write); end
        total++; if (snap_addr !== 34'h20) begin bad++; $display("FAIL write_paddr: got %h want 20", snap_addr); end
        total++; if (access_n !== 3)      begin bad++; $display("FAIL write_access_cycles: got %0d want 3", access_n); end
        total++; if (stable_bad !== 0)    begin bad++; $display("FAIL write_stable: got %0d changes want 0", stable_bad); end
        wait_states = 0;
    endtask

    task automatic test_masked_write();
        logic [7:0] cmd [10];
        logic [7:0] got;
        clear_mon();
        pslverr = 1'b0; wait_states = 1;
        cmd = '{8'h03, 8'h40, 8'h00, 8'h00, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h05};
        send_cmd(cmd, 10);
        wait_rsp(1);
        got = (rsp_q.size() > 0) ? rsp_q[0] : 8'hxx;
        total++; if (rsp_q.size() !== 1) begin bad++; $display("FAIL mwrite_rsp_len: got %0d want 1", rsp_q.size()); end
        total++; if (got !== 8'h00)      begin bad++; $display("FAIL mwrite_status: got %h want 00", got); end
        total++; if (snap_strb !== 4'b0101) begin bad++; $display("FAIL mwrite_pwstrb: got %b want 0101", snap_strb); end
        total++; if (snap_wdata !== 32'hAABBCCDD) begin bad++; $display("FAIL mwrite_pwdata: got %h want aabbccdd", snap_wdata); end
        total++; if (snap_addr !== 34'h40) begin bad++; $display("FAIL mwrite_paddr: got %h want 40", snap_addr); end
        total++; if (stable_bad !== 0)     begin bad++; $display("FAIL mwrite_stable: got %0d changes want 0", stable_bad); end
        wait_states = 0;
    endtask

    task automatic test_slverr_and_bad_op();
        logic [7:0] cmd [10];
        logic [7:0] exp [5];
        logic [7:0] got;
        clear_mon();
        prdata = 32'h11223344; pslverr = 1'b1; wait_states = 0;
        cmd = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 5);
        wait_rsp(5);
        exp = '{8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
        total++; if (rsp_q.size() !== 5) begin bad++; $display("FAIL slverr_rsp_len: got %0d want 5", rsp_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < rsp_q.size()) ? rsp_q[i] : 8'hxx;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL slverr_rsp_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        pslverr = 1'b0;

        clear_mon();
        send_byte(8'h7E);
        wait_rsp(1);
        got = (rsp_q.size() > 0) ? rsp_q[0] : 8'hxx;
        total++; if (rsp_q.size() !== 1) begin bad++; $display("FAIL badop_rsp_len: got %0d want 1", rsp_q.size()); end
        total++; if (got !== 8'hFF)      begin bad++; $display("FAIL badop_status: got %h want ff", got); end
        total++; if (setup_n !== 0 || access_n !== 0) begin bad++; $display("FAIL badop_apb_idle: got setup=%0d access=%0d want 0/0", setup_n, access_n); end
        total++; if (rx_ready !== 1'b1)  begin bad++; $display("FAIL badop_back_idle: got rx_ready=%b want 1", rx_ready); end
    endtask

    task automatic test_tx_stall();
        logic [7:0] cmd [10];
        logic [7:0] exp [5];
        logic [7:0] got;
        logic [7:0] held;
        int k = 0;
        int pos;
        clear_mon();
        prdata = 32'hCAFEF00D; pslverr = 1'b0; wait_states = 0;
        exp = '{8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        cmd = '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 5);
        while (rsp_q.size() < 2 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        tx_ready = 1'b0;
        pos  = rsp_q.size();
        held = tx_data;
        total++; if (pos !== 2) begin bad++; $display("FAIL stall_position: got %0d bytes before stall want 2", pos); end
        total++; if (held !== exp[2]) begin bad++; $display("FAIL stall_byte: got %h want %h", held, exp[2]); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (tx_valid !== 1'b1 || tx_data !== held) begin
                bad++;
                $display("FAIL stall_hold%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, held);
            end
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_rsp(5);
        total++; if (rsp_q.size() !== 5) begin bad++; $display("FAIL stall_rsp_len: got %0d want 5", rsp_q.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (i < rsp_q.size()) ? rsp_q[i] : 8'hxx;
            total++; if (got !== exp[i]) begin bad++; $display("FAIL stall_rsp_byte%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_reset_in_access();
        logic [7:0] cmd [10];
        int k = 0;
        clear_mon();
        hang = 1'b1;
        cmd = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 5);
        while (!(psel && penable) && k < 50) begin
            @(negedge clk);
            k++;
        end
        total++; if (!(psel && penable)) begin bad++; $display("FAIL rstacc_reach_access: got psel=%b penable=%b want 1/1", psel, penable); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (psel !== 1'b0 || penable !== 1'b0) begin bad++; $display("FAIL rstacc_psel_drop: got psel=%b penable=%b want 0/0", psel, penable); end
        rst  = 1'b0;
        hang = 1'b0;
        repeat (12) @(negedge clk);
        total++; if (txv_n !== 0) begin bad++; $display("FAIL rstacc_no_response: got %0d tx_valid cycles want 0", txv_n); end
        total++; if (rx_ready !== 1'b1) begin bad++; $display("FAIL rstacc_idle: got rx_ready=%b want 1", rx_ready); end
    endtask

`ifdef APB_DBG_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] cmd [10];
        logic [7:0] got;
        clear_mon();
        hang = 1'b1;
        cmd = '{8'h01, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(cmd, 5);
        wait_rsp(1);
        got = (rsp_q.size() > 0) ? rsp_q[0] : 8'hxx;
        total++; if (access_n !== 8)     begin bad++; $display("FAIL timeout_access_cycles: got %0d want 8", access_n); end
        total++; if (rsp_q.size() !== 1) begin bad++; $display("FAIL timeout_rsp_len: got %0d want 1", rsp_q.size()); end
        total++; if (got !== 8'h02)      begin bad++; $display("FAIL timeout_status: got %h want 02", got); end
        total++; if (psel !== 1'b0)      begin bad++; $display("FAIL timeout_psel: got %b want 0", psel); end
        hang = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        clear_mon();
        test_reset();
        test_read();
        test_write();
        test_masked_write();
        test_slverr_and_bad_op();
        test_tx_stall();
        test_reset_in_access();
`ifdef APB_DBG_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
